// File: rtl/tff_pkg.sv
// Shared constants, direction enum and next-value helper for the T-flip-flop
// modulo counter and its bench model.
package tff_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 10;
    localparam int DEF_WRAPW = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Modulo step of one count in the given direction.
    function automatic logic [31:0] next_val(input logic [31:0] q,
                                             input logic        up,
                                             input logic [31:0] modv);
        logic [31:0] r;
        if (up) begin
            r = (q == modv - 32'd1) ? 32'd0 : q + 32'd1;
        end else begin
            r = (q == 32'd0) ? modv - 32'd1 : q - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control and status bundle of the modulo counter: master drives the controls,
// slave (the counter) drives the state and status.
interface tff_mod_counter_if #(
    parameter int WIDTH = 4,
    parameter int WRAPW = 8
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic [WRAPW-1:0] wrap_cnt;

    modport master (
        output en, up_dn, load, load_val,
        input  q, t_vec, tc, wrap_cnt
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, t_vec, tc, wrap_cnt
    );
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: inverts on a clock edge when t is high, else holds.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    logic q_r;

    // Toggle register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= q_r ^ t;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/tff_mod_counter_chk.sv
// Invariant checker: each cell follows its toggle input, the state stays
// below the modulus, and the modulus is legal for the width.
module tff_mod_counter_chk #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] t_vec
);
    logic [WIDTH-1:0] q_prev_r;
    logic [WIDTH-1:0] t_prev_r;
    logic             rst_prev_r;
    logic             valid_r;

    // History of the previous edge, armed once a reset has been seen.
    always_ff @(posedge clk) begin
        q_prev_r   <= q;
        t_prev_r   <= t_vec;
        rst_prev_r <= rst;
        if (rst) begin
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Per-edge invariant checks against the previous edge's toggles.
    always_ff @(posedge clk) begin
        a_mod_range: assert (MOD >= 2 && MOD <= (1 << WIDTH))
            else $error("tff_mod_counter: MOD %0d outside 2..2**%0d", MOD, WIDTH);
        if (valid_r) begin
            a_q_lt_mod: assert (32'(q) < 32'(MOD))
                else $error("tff_mod_counter: q=%0d not below MOD", q);
            if (rst_prev_r) begin
                a_rst_zero: assert (q == {WIDTH{1'b0}})
                    else $error("tff_mod_counter: q=%0d after reset", q);
            end else begin
                a_cell: assert (q == (q_prev_r ^ t_prev_r))
                    else $error("tff_mod_counter: cells q=%b prev=%b t=%b",
                                q, q_prev_r, t_prev_r);
            end
        end
    end
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built from T flip-flop cells; computes the
// per-bit toggle vector, terminal count and a saturating wrap counter.
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD,
    parameter int WRAPW = DEF_WRAPW
) (
    input logic                clk,
    input logic                rst,
    tff_mod_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MOD - 1);
    localparam logic [31:0]      MOD32 = 32'(MOD);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_n_s;
    logic [WIDTH-1:0] t_s;
    logic             up_s;
    logic             tc_s;
    logic [WRAPW-1:0] wrap_r;

    assign up_s = (dir_e'(bus.up_dn) == DIR_UP);

    // Next state by priority load > enable > hold, expressed as cell toggles.
    always_comb begin
        q_n_s = q_s;
        t_s   = {WIDTH{1'b0}};
        if (bus.load) begin
            q_n_s = (32'(bus.load_val) < MOD32) ? bus.load_val : Q_MAX;
        end else if (bus.en) begin
            q_n_s = WIDTH'(next_val(32'(q_s), up_s, MOD32));
        end else begin
            q_n_s = q_s;
        end
        if (rst) begin
            t_s = {WIDTH{1'b0}};
        end else begin
            t_s = q_s ^ q_n_s;
        end
    end

    // Terminal count: high only in the cycle before a counting wrap.
    always_comb begin
        tc_s = 1'b0;
        if (bus.en && !bus.load && !rst) begin
            tc_s = up_s ? (q_s == Q_MAX) : (q_s == {WIDTH{1'b0}});
        end else begin
            tc_s = 1'b0;
        end
    end

    // Saturating count of wraps since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_r <= {WRAPW{1'b0}};
        end else if (tc_s && (wrap_r != {WRAPW{1'b1}})) begin
            wrap_r <= wrap_r + {{(WRAPW-1){1'b0}}, 1'b1};
        end else begin
            wrap_r <= wrap_r;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_s[i]),
            .q   (q_s[i])
        );
    end

    tff_mod_counter_chk #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .q     (q_s),
        .t_vec (t_s)
    );

    assign bus.q        = q_s;
    assign bus.t_vec    = t_s;
    assign bus.tc       = tc_s;
    assign bus.wrap_cnt = wrap_r;
endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter (WIDTH=4, MOD=10) with a second
// instance using a 2-bit wrap counter to observe saturation.
module tb_tff_mod_counter;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    tff_mod_counter_if #(.WIDTH(4), .WRAPW(8)) bus ();
    tff_mod_counter_if #(.WIDTH(4), .WRAPW(2)) bus_sat ();

    tff_mod_counter #(.WIDTH(4), .MOD(10), .WRAPW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    tff_mod_counter #(.WIDTH(4), .MOD(10), .WRAPW(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat.slave)
    );

    assign bus_sat.en       = bus.en;
    assign bus_sat.up_dn    = bus.up_dn;
    assign bus_sat.load     = bus.load;
    assign bus_sat.load_val = bus.load_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eq;
        int nq;
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.up_dn = 1'b1;
        bus.load = 1'b0;
        bus.load_val = 4'd0;

        // Reset, then up count through one wrap.
        tick();
        tick();
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_wrap", 32'(bus.wrap_cnt), 32'd0);
        bus.en = 1'b1;
        #1;
        chk("rst_tc", 32'(bus.tc), 32'd0);
        chk("rst_t", 32'(bus.t_vec), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            eq = k % 10;
            nq = (k + 1) % 10;
            chk("up_q", 32'(bus.q), 32'(eq));
            chk("up_tc", 32'(bus.tc), (eq == 9) ? 32'd1 : 32'd0);
            chk("up_t", 32'(bus.t_vec), 32'(eq ^ nq));
            if (eq == 7) chk("up_t_7to8", 32'(bus.t_vec), 32'b1111);
            tick();
        end
        chk("up_end_q", 32'(bus.q), 32'd2);
        chk("up_wrap", 32'(bus.wrap_cnt), 32'd1);

        // Down wrap from zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.up_dn = 1'b0;
        #1;
        chk("dn_q0", 32'(bus.q), 32'd0);
        chk("dn_tc0", 32'(bus.tc), 32'd1);
        chk("dn_t0", 32'(bus.t_vec), 32'b1001);
        tick();
        chk("dn_q9", 32'(bus.q), 32'd9);
        chk("dn_tc9", 32'(bus.tc), 32'd0);
        chk("dn_t9", 32'(bus.t_vec), 32'b0001);
        tick();
        chk("dn_q8", 32'(bus.q), 32'd8);
        chk("dn_wrap", 32'(bus.wrap_cnt), 32'd1);

        // Load, clamp, and load overriding a wrap.
        bus.en = 1'b0;
        bus.load = 1'b1;
        bus.load_val = 4'd6;
        #1;
        chk("ld6_tc", 32'(bus.tc), 32'd0);
        chk("ld6_t", 32'(bus.t_vec), 32'b1110);
        tick();
        chk("ld6_q", 32'(bus.q), 32'd6);
        bus.load_val = 4'd13;
        #1;
        chk("ld13_t", 32'(bus.t_vec), 32'b1111);
        tick();
        chk("ld13_q", 32'(bus.q), 32'd9);
        bus.en = 1'b1;
        bus.up_dn = 1'b1;
        bus.load_val = 4'd4;
        #1;
        chk("ld_en_tc", 32'(bus.tc), 32'd0);
        chk("ld_en_t", 32'(bus.t_vec), 32'b1101);
        tick();
        chk("ld_en_q", 32'(bus.q), 32'd4);
        chk("ld_en_wrap", 32'(bus.wrap_cnt), 32'd1);

        // Hold at 3.
        bus.en = 1'b0;
        bus.load_val = 4'd3;
        tick();
        bus.load = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_t", 32'(bus.t_vec), 32'd0);
            chk("hold_tc", 32'(bus.tc), 32'd0);
            tick();
            chk("hold_q", 32'(bus.q), 32'd3);
        end

        // Reset mid-count wins over load and enable.
        bus.load = 1'b1;
        bus.load_val = 4'd5;
        tick();
        chk("mid_q5", 32'(bus.q), 32'd5);
        rst = 1'b1;
        bus.en = 1'b1;
        bus.load_val = 4'd2;
        #1;
        chk("mid_tc", 32'(bus.tc), 32'd0);
        chk("mid_t", 32'(bus.t_vec), 32'd0);
        tick();
        chk("mid_q", 32'(bus.q), 32'd0);
        chk("mid_wrap", 32'(bus.wrap_cnt), 32'd0);
        rst = 1'b0;
        bus.load = 1'b0;
        tick();
        chk("resume_q1", 32'(bus.q), 32'd1);
        tick();
        chk("resume_q2", 32'(bus.q), 32'd2);

        // Five full up wraps: 8-bit counter keeps counting, 2-bit one saturates.
        rst = 1'b1;
        tick();
        chk("sat_rst", 32'(bus_sat.wrap_cnt), 32'd0);
        rst = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            repeat (10) tick();
            chk("sat_q", 32'(bus.q), 32'd0);
            chk("wrap8", 32'(bus.wrap_cnt), 32'(w));
            chk("wrap2", 32'(bus_sat.wrap_cnt), (w > 3) ? 32'd3 : 32'(w));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
